fp_divider: RTL and testbench
=============================

FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have no parameters; the operand format is fixed to IEEE-754 single precision (1 sign, 8 exponent, 23 fraction bits).
REQ-002 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL provide: A  input  32  dividend; captured on the accepted start.
REQ-006 SHALL provide: B  input  32  divisor; captured on the accepted start.
REQ-007 SHALL provide: result  output  32  quotient; held stable from done until the next accepted start.
REQ-008 SHALL provide: busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL provide: done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL provide: div_by_zero  output  1  high with done when B was zero and A was non-zero; holds until the next accepted start.

Function
REQ-011 SHALL implement states IDLE, DIVIDE, NORMALIZE and DONE.
REQ-012 SHALL accept start only in IDLE; start while busy is ignored, and latched operands do not change.
REQ-013 SHALL, on the accepting edge (E0), latch the operands, clear div_by_zero and go to DIVIDE with iteration count 0, unless a special case (REQ-017) applies.
REQ-014 SHALL run a restoring division of {1,A[22:0]} by {1,B[22:0]}, one quotient bit per edge, over 25 edges (E1..E25), then go to NORMALIZE.
- Each step: if remainder >= divisor, the quotient bit is 1 and the divisor is subtracted.
- The remainder is then shifted left by 1.
- The first bit produced is q[24].
REQ-015 SHALL, at E26 in NORMALIZE, write result, enter DONE and assert done for exactly one cycle, then return to IDLE at E27.
- If q[24]=1: fraction = q[23:1], exponent = Ea-Eb+127.
- Else: fraction = q[22:0], exponent = Ea-Eb+126.
- Sign = A[31]^B[31].
- Truncate the quotient; no rounding.
REQ-016 SHALL compute the exponent in 10-bit signed arithmetic before the final 8-bit selection.
REQ-017 SHALL handle special cases at E0: go directly to DONE, with done high after E1.
- A==32'b0: result = 32'b0 (this takes priority).
- Otherwise B==32'b0: result = {sign, 8'hFF, 23'b0} and div_by_zero = 1.
REQ-018 SHALL NOT treat denormals, NaN or infinity specially; exponent fields are used as given and the hidden bit is always 1.

Reset
REQ-019 SHALL, while rst is high (at any time, including mid-operation), force state to IDLE, result to 0, busy to 0, done to 0, div_by_zero to 0 and the iteration count to 0.
REQ-020 SHALL NOT produce a done pulse for an operation aborted by reset.

Configuration
REQ-021 SHALL honour macro FP_DIV_SATURATE_EN.
- Defined: an exponent above 254 gives {sign, 8'hFF, 23'b0}; an exponent below 1 gives {sign, 31'b0}.
- Undefined: the low 8 exponent bits are used unchanged (wrap-around).

Structure
REQ-022 SHALL take the following from shared package fp_pkg:
- fp32_t (packed struct: sign, exp, frac)
- the state enum
- constants FP_BIAS=127, FP_EXP_MAX=8'hFF and QUOT_BITS=25
REQ-023 SHALL place the remainder/quotient shift-subtract datapath and the iteration counter in sub-module fp_mant_divider; fp_divider owns the FSM, exponent/sign logic and the output registers.

Verification
REQ-024 SHALL cover: A=0x40C00000 (6.0), B=0x40000000 (2.0) -> result 0x40400000, done exactly 26 edges after E0, busy high throughout.
REQ-025 SHALL cover: A=0x3F800000, B=0x40400000 -> 0x3EAAAAAA (truncated 1/3), div_by_zero=0.
REQ-026 SHALL cover: A=0xC0C00000, B=0x40000000 -> 0xC0400000; a start pulse with other operands mid-operation leaves the result unchanged.
REQ-027 SHALL cover:
- A=0, B=0x40A00000 -> result 0x00000000, done after 1 edge.
- A=0x40A00000, B=0 -> result 0x7F800000, div_by_zero=1.
REQ-028 SHALL cover: A=0x7F000000, B=0x00800000.
- With FP_DIV_SATURATE_EN: result 0x7F800000.
- Without it: result 0x3E000000.
REQ-029 SHALL cover: rst asserted at iteration 10 -> busy, done, result all 0 immediately; no done pulse; the next start completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision divider.
// The saturating exponent selection is built when FP_DIV_SATURATE_EN is defined.
package fp_pkg;

  localparam int          FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int          QUOT_BITS  = 25;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIVIDE    = 2'd1,
    NORMALIZE = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Map the wide signed exponent onto the 8-bit field (wrap or saturate).
  function automatic fp32_t pack_quotient(input logic sign, input logic signed [9:0] exp_wide,
                                          input logic [22:0] frac);
    fp32_t word;
    word.sign = sign;
    word.exp  = exp_wide[7:0];
    word.frac = frac;
`ifdef FP_DIV_SATURATE_EN
    if (exp_wide > 10'sd254) begin
      word.exp  = FP_EXP_MAX;
      word.frac = '0;
    end else if (exp_wide < 10'sd1) begin
      word.exp  = '0;
      word.frac = '0;
    end
`else
    if (exp_wide[9:8] != 2'b00) begin
      word.exp = exp_wide[7:0];
    end
`endif
    return word;
  endfunction

endpackage

// File: rtl/fp_mant_divider.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
import fp_pkg::*;

module fp_mant_divider (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [23:0]          dividend,
  input  logic [23:0]          divisor,
  output logic [QUOT_BITS-1:0] quot,
  output logic                 last
);

  logic [24:0]          rem_reg;
  logic [23:0]          div_reg;
  logic [QUOT_BITS-1:0] quot_reg;
  logic [4:0]           count_reg;
  logic [24:0]          diff;
  logic                 fits;

  // Remainder stays below twice the divisor, so 25 bits always suffice.
  assign fits = (rem_reg >= {1'b0, div_reg});
  assign diff = rem_reg - {1'b0, div_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg   <= '0;
      div_reg   <= '0;
      quot_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      rem_reg   <= {1'b0, dividend};
      div_reg   <= divisor;
      quot_reg  <= '0;
      count_reg <= '0;
    end else if (step) begin
      quot_reg  <= {quot_reg[QUOT_BITS-2:0], fits};
      rem_reg   <= fits ? (diff << 1) : (rem_reg << 1);
      count_reg <= count_reg + 5'd1;
    end
  end

  assign quot = quot_reg;
  assign last = (count_reg == 5'(QUOT_BITS - 1));

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider, truncating, multi-cycle FSM.
// Define FP_DIV_SATURATE_EN to clamp out-of-range exponents instead of wrapping.
import fp_pkg::*;

module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  state_t               state;
  fp32_t                a_in, b_in;
  logic                 sign_reg;
  logic [7:0]           ea_reg, eb_reg;
  logic                 load, step, last;
  logic [QUOT_BITS-1:0] quot;
  logic signed [9:0]    exp_wide;
  logic [22:0]          frac_norm;
  fp32_t                norm_word;

  assign a_in = A;
  assign b_in = B;
  assign load = (state == IDLE) && start && (A != 32'b0) && (B != 32'b0);
  assign step = (state == DIVIDE);
  assign busy = (state != IDLE);

  fp_mant_divider u_mant (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .dividend ({1'b1, a_in.frac}),
    .divisor  ({1'b1, b_in.frac}),
    .quot     (quot),
    .last     (last)
  );

  // A quotient below 1.0 needs one extra left shift, hence bias-1.
  always_comb begin
    exp_wide  = $signed({2'b00, ea_reg}) - $signed({2'b00, eb_reg})
              + (quot[QUOT_BITS-1] ? 10'sd127 : 10'sd126);
    frac_norm = quot[QUOT_BITS-1] ? quot[23:1] : quot[22:0];
    norm_word = pack_quotient(sign_reg, exp_wide, frac_norm);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      result      <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      sign_reg    <= 1'b0;
      ea_reg      <= '0;
      eb_reg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_reg    <= a_in.sign ^ b_in.sign;
            ea_reg      <= a_in.exp;
            eb_reg      <= b_in.exp;
            div_by_zero <= 1'b0;
            if (A == 32'b0) begin
              result <= '0;
              state  <= DONE;
            end else if (B == 32'b0) begin
              result      <= {a_in.sign ^ b_in.sign, FP_EXP_MAX, 23'b0};
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (last) state <= NORMALIZE;
        end
        NORMALIZE: begin
          result <= norm_word;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: begin
          // Special cases arrive with done low and pulse it one edge later.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed cases, reset abort, random ops vs. arithmetic model.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        busy, done, div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  fp_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer quotient of the significands, then IEEE field packing.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, q;
    int     e;
    logic   s;
    logic [22:0] frac;
    s = a[31] ^ b[31];
    if (a == 32'b0) return 33'b0;
    if (b == 32'b0) return {1'b1, s, 8'hFF, 23'b0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma * 64'd16777216) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= 64'd16777216) frac = 23'((q / 2) % 64'd8388608);
    else begin
      frac = 23'(q % 64'd8388608);
      e    = e - 1;
    end
`ifdef FP_DIV_SATURATE_EN
    if (e > 254) return {1'b0, s, 8'hFF, 23'b0};
    if (e < 1)   return {1'b0, s, 31'b0};
`endif
    return {1'b0, s, 8'(e & 255), frac};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke,
                        input string tag, output logic [31:0] got);
    logic [32:0] ref_v;
    int          exp_lat, lat;
    bit          busy_gap;
    ref_v    = model(a, b);
    exp_lat  = (a == 32'b0 || b == 32'b0) ? 1 : 26;
    busy_gap = 1'b0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      if (!busy) busy_gap = 1'b1;
      if (poke && lat == 5) begin
        A = $urandom; B = $urandom | 32'h1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    got = result;
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " busy_gap"}, {31'b0, busy_gap}, 32'd0);
    check_eq({tag, " busy_at_done"}, {31'b0, busy}, 32'd1);
    check_eq({tag, " result"}, result, ref_v[31:0]);
    check_eq({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, ref_v[32]});
    $display("op %s A=%08h B=%08h result=%08h dbz=%0b lat=%0d", tag, a, b, result, div_by_zero, lat);
    @(posedge clk); #1;
    check_eq({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    check_eq({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, " hold"}, result, ref_v[31:0]);
    check_eq({tag, " hold_dbz"}, {31'b0, div_by_zero}, {31'b0, ref_v[32]});
  endtask

  logic [31:0] dir_a   [6] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000,
                               32'h00000000, 32'h40A00000, 32'h7F000000};
  logic [31:0] dir_b   [6] = '{32'h40000000, 32'h40400000, 32'h40000000,
                               32'h40A00000, 32'h00000000, 32'h00800000};
`ifdef FP_DIV_SATURATE_EN
  logic [31:0] dir_exp [6] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000,
                               32'h00000000, 32'h7F800000, 32'h7F800000};
`else
  logic [31:0] dir_exp [6] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000,
                               32'h00000000, 32'h7F800000, 32'h3E000000};
`endif

  initial begin
    logic [31:0] got, ra, rb;
    bit          seen;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset result", result, 32'h0);
    check_eq("reset busy", {31'b0, busy}, 32'd0);
    check_eq("reset done", {31'b0, done}, 32'd0);
    check_eq("reset dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(dir_a[i], dir_b[i], (i == 2), $sformatf("dir%0d", i), got);
      check_eq($sformatf("dir%0d const", i), got, dir_exp[i]);
    end

    // Abort at iteration 10 with reset; no done may follow.
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort busy", {31'b0, busy}, 32'd0);
    check_eq("abort done", {31'b0, done}, 32'd0);
    check_eq("abort result", result, 32'h0);
    check_eq("abort dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check_eq("abort no_done", {31'b0, seen}, 32'd0);
    $display("op abort A=40c00000 B=40000000 reset at iteration 10");
    run_op(32'h40C00000, 32'h40000000, 1'b0, "after_abort", got);
    check_eq("after_abort const", got, 32'h40400000);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra = 32'h0;
        1: rb = 32'h0;
        default: ;
      endcase
      run_op(ra, rb, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
